// File: rtl/sim_mon_pkg.sv
// Shared types and helpers for the end-of-simulation monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sim_mon_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        PASS    = 3'd1,
        FAIL    = 3'd2,
        HANG    = 3'd3,
        TIMEOUT = 3'd4
    } mon_state_e;

    localparam logic [63:0] PASS_VAL_DEF = 64'h444333222;
    localparam logic [63:0] FAIL_VAL_DEF = 64'h2382348720;

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sim_mon_cfifo.sv
// Console character FIFO with sticky overflow flag.
// Latency: push visible on the head the cycle after it is written.
// Backpressure: push while full (and no pop) is dropped and sets ovf; pop while empty is ignored.
module sim_mon_cfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop_rdy & ~empty;
    // A pop frees the slot this same edge, so a push into a full FIFO is still taken.
    assign do_push = push_vld & (~full | do_pop);
    assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_vld && !do_push) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sim_end_monitor.sv
// End-of-simulation monitor: PASS/FAIL/HANG/TIMEOUT detection plus console char snoop.
// Latency: state change one cycle after the event; console char on char_vld one cycle after the W beat.
// Backpressure: none upstream (pure snoop); console chars dropped with char_ovf when the FIFO is full.
module sim_end_monitor
    import sim_mon_pkg::*;
#(
    parameter int                 RETIRE_N    = 2,
    parameter int                 WB_N        = 2,
    parameter int                 WB_W        = 64,
    parameter logic [WB_W-1:0]    PASS_VAL    = WB_W'(PASS_VAL_DEF),
    parameter logic [WB_W-1:0]    FAIL_VAL    = WB_W'(FAIL_VAL_DEF),
    parameter int unsigned        WD_PERIOD   = 50000,
    parameter int unsigned        MAX_CYCLES  = 70000000,
    parameter int                 ADDR_W      = 40,
    parameter int                 BUS_W       = 128,
    parameter logic [ADDR_W-1:0]  PRINT_ADDR  = ADDR_W'(40'h90000000),
    parameter int                 CFIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   mon_en,
    input  logic [RETIRE_N-1:0]    retire,
    input  logic [WB_N-1:0]        wb_vld,
    input  logic [WB_N*WB_W-1:0]   wb_data,
    input  logic                   awvalid,
    input  logic                   awready,
    input  logic [ADDR_W-1:0]      awaddr,
    input  logic [3:0]             awlen,
    input  logic                   wvalid,
    input  logic                   wready,
    input  logic [BUS_W/8-1:0]     wstrb,
    input  logic [BUS_W-1:0]       wdata,
    output logic                   sim_done,
    output logic [2:0]             sim_state,
    output logic [63:0]            retired_cnt,
    output logic                   char_vld,
    output logic [7:0]             char_data,
    input  logic                   char_rdy,
    output logic                   char_ovf
);

    localparam int              WD_W    = (WD_PERIOD > 1) ? $clog2(WD_PERIOD) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_PERIOD - 1);
    localparam logic [63:0]     CYC_END = 64'(MAX_CYCLES) - 64'd1;
    localparam int              NGRP    = BUS_W / 32;
    localparam int              STRB_W  = BUS_W / 8;

    mon_state_e      state;
    logic [63:0]     cyc_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_seen;
    logic            aw_hit;

    logic            pass_ev, fail_ev, hang_ev, tmo_ev;
    logic            any_retire, wd_end;
    logic            aw_hs, w_hs, aw_match, hit_now;
    logic            strb_ok, char_push;
    logic [7:0]      strb_char;
    logic            fifo_full, fifo_empty;
    logic            unused_bits;

    always_comb begin
        pass_ev = 1'b0;
        fail_ev = 1'b0;
        for (int k = 0; k < WB_N; k++) begin
            if (wb_vld[k] && wb_data[k*WB_W +: WB_W] == PASS_VAL) pass_ev = 1'b1;
            if (wb_vld[k] && wb_data[k*WB_W +: WB_W] == FAIL_VAL) fail_ev = 1'b1;
        end
        any_retire = |retire;
        wd_end     = (wd_cnt == WD_LAST);
        // A retire in the window's final cycle still rescues that window.
        hang_ev    = wd_end & ~(wd_seen | any_retire);
        tmo_ev     = (MAX_CYCLES != 0) && (cyc_cnt == CYC_END);
    end

    always_comb begin
        aw_hs     = awvalid & awready;
        w_hs      = wvalid & wready;
        aw_match  = aw_hs && (awlen == 4'd0) && (awaddr == PRINT_ADDR);
        hit_now   = aw_hs ? aw_match : aw_hit;
        strb_ok   = 1'b0;
        strb_char = '0;
        for (int g = 0; g < NGRP; g++) begin
            if (wstrb == (STRB_W'(4'hf) << (4 * g))) begin
                strb_ok   = 1'b1;
                strb_char = wdata[g*32 +: 8];
            end
        end
        char_push = mon_en & w_hs & hit_now & strb_ok;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            retired_cnt <= '0;
            cyc_cnt     <= '0;
            wd_cnt      <= '0;
            wd_seen     <= 1'b0;
            aw_hit      <= 1'b0;
        end else if (mon_en) begin
            retired_cnt <= retired_cnt + 64'(popcount(64'(retire)));
            cyc_cnt     <= cyc_cnt + 64'd1;
            if (wd_end) begin
                wd_cnt  <= '0;
                wd_seen <= 1'b0;
            end else begin
                wd_cnt  <= wd_cnt + 1'b1;
                wd_seen <= wd_seen | any_retire;
            end
            if (w_hs && hit_now) begin
                aw_hit <= 1'b0;
            end else if (aw_hs) begin
                aw_hit <= aw_match;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= RUN;
            sim_done <= 1'b0;
        end else if (mon_en && state == RUN) begin
            if (pass_ev) begin
                state    <= PASS;
                sim_done <= 1'b1;
            end else if (fail_ev) begin
                state    <= FAIL;
                sim_done <= 1'b1;
            end else if (hang_ev) begin
                state    <= HANG;
                sim_done <= 1'b1;
            end else if (tmo_ev) begin
                state    <= TIMEOUT;
                sim_done <= 1'b1;
            end
        end
    end

    assign sim_state = state;

    sim_mon_cfifo #(
        .WIDTH (8),
        .DEPTH (CFIFO_DEPTH)
    ) u_cfifo (
        .clk      (clk),
        .rst_b    (rst_b),
        .push_vld (char_push),
        .push_dat (strb_char),
        .pop_rdy  (char_rdy),
        .pop_dat  (char_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .ovf      (char_ovf)
    );

    assign char_vld    = ~fifo_empty;
    assign unused_bits = ^{wdata, fifo_full};

endmodule

// File: tb/tb_sim_end_monitor.sv
// Scoreboard bench for sim_end_monitor: expected terminal events and console chars are queued
// at stimulus time and popped by monitors when the DUT raises sim_done or presents a char.
module tb_sim_end_monitor;

    localparam logic [63:0] PASS_V = 64'h444333222;
    localparam logic [63:0] FAIL_V = 64'h2382348720;
    localparam logic [39:0] PADDR  = 40'h90000000;
    localparam logic [2:0]  S_RUN = 3'd0, S_PASS = 3'd1, S_FAIL = 3'd2, S_HANG = 3'd3, S_TMO = 3'd4;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          mon_en;
    logic [1:0]    retire;
    logic [1:0]    wb_vld;
    logic [127:0]  wb_data;
    logic          awvalid, awready, wvalid, wready;
    logic [39:0]   awaddr;
    logic [3:0]    awlen;
    logic [15:0]   wstrb;
    logic [127:0]  wdata;
    logic          sim_done, char_vld, char_rdy, char_ovf;
    logic [2:0]    sim_state;
    logic [63:0]   retired_cnt;
    logic [7:0]    char_data;

    int checks = 0;
    int errors = 0;
    int edges;
    logic prev_done = 1'b0;

    typedef struct {
        logic [2:0]  st;
        logic [63:0] cnt;
        int          cyc;
        string       name;
    } term_t;

    term_t      term_q[$];
    logic [7:0] char_q[$];

    always #5 clk = ~clk;

    sim_end_monitor #(
        .WD_PERIOD  (16),
        .MAX_CYCLES (1000)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .mon_en      (mon_en),
        .retire      (retire),
        .wb_vld      (wb_vld),
        .wb_data     (wb_data),
        .awvalid     (awvalid),
        .awready     (awready),
        .awaddr      (awaddr),
        .awlen       (awlen),
        .wvalid      (wvalid),
        .wready      (wready),
        .wstrb       (wstrb),
        .wdata       (wdata),
        .sim_done    (sim_done),
        .sim_state   (sim_state),
        .retired_cnt (retired_cnt),
        .char_vld    (char_vld),
        .char_data   (char_data),
        .char_rdy    (char_rdy),
        .char_ovf    (char_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Posedges since reset release; at the following negedge this is the "cycle k+1" index.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) edges <= 0;
        else        edges <= edges + 1;
    end

    always @(negedge clk) begin
        if (sim_done && !prev_done) begin
            if (term_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL term_unexpected: state %0d at cycle %0d", sim_state, edges);
            end else begin
                term_t t;
                t = term_q.pop_front();
                chk({t.name, "_state"}, 64'(sim_state), 64'(t.st));
                chk({t.name, "_retired"}, retired_cnt, t.cnt);
                chk({t.name, "_cycle"}, 64'(edges), 64'(t.cyc));
            end
        end
        prev_done = sim_done;
    end

    always @(negedge clk) begin
        if (rst_b && char_vld && char_rdy) begin
            if (char_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL char_unexpected: got %0h, expected none", char_data);
            end else begin
                chk("char", 64'(char_data), 64'(char_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        mon_en  = 1'b1;
        retire  = '0;
        wb_vld  = '0;
        wb_data = '0;
        awvalid = 1'b0;
        awready = 1'b1;
        awaddr  = '0;
        awlen   = '0;
        wvalid  = 1'b0;
        wready  = 1'b1;
        wstrb   = '0;
        wdata   = '0;
    endtask

    task automatic do_reset();
        rst_b    = 1'b0;
        char_rdy = 1'b0;
        idle_in();
        step();
        step();
        chk("rst_state", 64'(sim_state), 64'(S_RUN));
        chk("rst_done", 64'(sim_done), 64'd0);
        chk("rst_retired", retired_cnt, 64'd0);
        chk("rst_char_vld", 64'(char_vld), 64'd0);
        chk("rst_char_ovf", 64'(char_ovf), 64'd0);
        rst_b = 1'b1;
    endtask

    task automatic aw_cyc(input logic [39:0] a, input logic [3:0] len);
        awvalid = 1'b1; awaddr = a; awlen = len;
        step();
        awvalid = 1'b0;
    endtask

    task automatic w_cyc(input logic [15:0] s, input logic [127:0] d);
        wvalid = 1'b1; wstrb = s; wdata = d;
        step();
        wvalid = 1'b0;
    endtask

    task automatic aww_cyc(input logic [15:0] s, input logic [127:0] d);
        awvalid = 1'b1; awaddr = PADDR; awlen = 4'd0;
        wvalid  = 1'b1; wstrb = s; wdata = d;
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic term_done(input string name);
        chk({name, "_term_seen"}, 64'(term_q.size()), 64'd0);
    endtask

    initial begin
        logic [127:0] d;
        idle_in();
        char_rdy = 1'b0;

        // PASS on port 1 after 100 retiring cycles; state then holds while counting continues
        do_reset();
        retire = 2'b01;
        repeat (100) step();
        retire  = 2'b00;
        wb_vld  = 2'b10;
        wb_data = {PASS_V, 64'd0};
        term_q.push_back('{st: S_PASS, cnt: 64'd100, cyc: 101, name: "t1"});
        step();
        wb_vld  = 2'b01;
        wb_data = {64'd0, FAIL_V};
        retire  = 2'b11;
        repeat (3) step();
        term_done("t1");
        chk("t1_hold_state", 64'(sim_state), 64'(S_PASS));
        chk("t1_retired_after", retired_cnt, 64'd106);

        // PASS beats FAIL in the same cycle
        do_reset();
        retire = 2'b01;
        repeat (10) step();
        wb_vld  = 2'b11;
        wb_data = {PASS_V, FAIL_V};
        term_q.push_back('{st: S_PASS, cnt: 64'd11, cyc: 11, name: "t2a"});
        step();
        wb_vld = 2'b00;
        step();
        term_done("t2a");

        // FAIL alone, ignored while mon_en is low
        do_reset();
        retire = 2'b01;
        repeat (5) step();
        mon_en  = 1'b0;
        wb_vld  = 2'b01;
        wb_data = {64'd0, FAIL_V};
        repeat (3) step();
        chk("t2b_frozen_state", 64'(sim_state), 64'(S_RUN));
        chk("t2b_frozen_retired", retired_cnt, 64'd5);
        mon_en = 1'b1;
        retire = 2'b00;
        term_q.push_back('{st: S_FAIL, cnt: 64'd5, cyc: 9, name: "t2b"});
        step();
        wb_vld = 2'b00;
        step();
        term_done("t2b");

        // HANG: retire stops at cycle 20, window [32..47] idle
        do_reset();
        retire = 2'b01;
        repeat (20) step();
        retire = 2'b00;
        repeat (12) step();
        chk("t3a_run_at_32", 64'(sim_state), 64'(S_RUN));
        term_q.push_back('{st: S_HANG, cnt: 64'd20, cyc: 48, name: "t3a"});
        repeat (17) step();
        term_done("t3a");

        // Retire only in the last cycle of window [16..31] keeps that window alive
        do_reset();
        retire = 2'b01;
        repeat (16) step();
        retire = 2'b00;
        repeat (15) step();
        retire = 2'b10;
        step();
        retire = 2'b00;
        chk("t3b_run_at_32", 64'(sim_state), 64'(S_RUN));
        term_q.push_back('{st: S_HANG, cnt: 64'd17, cyc: 48, name: "t3b"});
        repeat (17) step();
        term_done("t3b");

        // Console snoop
        do_reset();
        retire   = 2'b01;
        char_rdy = 1'b1;
        aw_cyc(PADDR, 4'd0);
        d = '0; d[71:64] = 8'h41;
        char_q.push_back(8'h41);
        w_cyc(16'h0f00, d);
        aw_cyc(PADDR, 4'd0);
        d = '0; d[7:0] = 8'h51;
        w_cyc(16'h0003, d);
        aw_cyc(PADDR, 4'd1);
        w_cyc(16'h000f, d);
        d = '0; d[103:96] = 8'h42;
        char_q.push_back(8'h42);
        aww_cyc(16'hf000, d);
        aw_cyc(PADDR, 4'd0);
        aw_cyc(PADDR + 40'h10, 4'd0);
        w_cyc(16'h000f, d);
        aw_cyc(PADDR, 4'd0);
        d = '0; d[7:0] = 8'h43;
        char_q.push_back(8'h43);
        w_cyc(16'h000f, d);
        d[7:0] = 8'h44;
        w_cyc(16'h000f, d);
        repeat (3) step();
        chk("t4_chars_drained", 64'(char_q.size()), 64'd0);
        chk("t4_no_ovf", 64'(char_ovf), 64'd0);

        // Overflow: 9 chars into 8 slots with no pops
        char_rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            d = '0;
            d[7:0] = 8'(8'h30 + i);
            if (i < 8) char_q.push_back(d[7:0]);
            aww_cyc(16'h000f, d);
        end
        chk("t5_ovf", 64'(char_ovf), 64'd1);
        chk("t5_vld", 64'(char_vld), 64'd1);
        chk("t5_head", 64'(char_data), 64'h30);
        char_rdy = 1'b1;
        repeat (10) step();
        chk("t5_drained_vld", 64'(char_vld), 64'd0);
        chk("t5_drained_q", 64'(char_q.size()), 64'd0);

        // Async reset mid-run clears everything, then TIMEOUT at cycle 1000
        char_rdy = 1'b0;
        repeat (300) step();
        d = '0; d[7:0] = 8'h5a;
        aww_cyc(16'h000f, d);
        chk("t6_pre_vld", 64'(char_vld), 64'd1);
        rst_b = 1'b0;
        #1;
        chk("t6_async_state", 64'(sim_state), 64'(S_RUN));
        chk("t6_async_retired", retired_cnt, 64'd0);
        chk("t6_async_vld", 64'(char_vld), 64'd0);
        chk("t6_async_ovf", 64'(char_ovf), 64'd0);
        do_reset();
        retire = 2'b01;
        term_q.push_back('{st: S_TMO, cnt: 64'd1000, cyc: 1000, name: "t6"});
        repeat (999) step();
        chk("t6_run_at_999", 64'(sim_state), 64'(S_RUN));
        repeat (2) step();
        term_done("t6");
        chk("t6_done", 64'(sim_done), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete, limit 200000 ns");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
